// File: rtl/afe_sar_pkg.sv
// Shared types and sizing helpers for the SAR ADC sequencer of the analog pin macro.
package afe_sar_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWRUP  = 3'd1,
        ST_IDLE   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DECIDE = 3'd5,
        ST_DONE   = 3'd6
    } sar_state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_PWRUP_CYCLES  = 16;
    localparam int DEF_SAMPLE_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Phase counter must hold the longest phase length without wrapping.
    function automatic int cnt_bits(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W = cnt_bits(DEF_PWRUP_CYCLES, DEF_SAMPLE_CYCLES, DEF_SETTLE_CYCLES);
    localparam int PTR_W = $clog2(DEF_WIDTH);

endpackage

// File: rtl/afe_sar_if.sv
// Host-side request/status bundle of the SAR sequencer; master is the pin mapping,
// slave is the sequencer.
interface afe_sar_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic             cont_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             overrun_o;

    modport master (
        output start_i, cont_i,
        input  ready_o, busy_o, done_o, result_o, overrun_o
    );

    modport slave (
        input  start_i, cont_i,
        output ready_o, busy_o, done_o, result_o, overrun_o
    );
endinterface

// File: rtl/afe_sync2.sv
// Two-flop synchronizer for the asynchronous AFE comparator output.
module afe_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Metastability filter: two back-to-back flops clearing to 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/afe_sar_sequencer.sv
// SAR ADC sequencer for the analog pin macro: powers the AFE, runs track/hold,
// walks DAC trial codes MSB-first and publishes the resolved result word.
module afe_sar_sequencer
    import afe_sar_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int PWRUP_CYCLES  = DEF_PWRUP_CYCLES,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    afe_sar_if.slave         host,
    input  logic             cmp_i,
    output logic             afe_en_o,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code_o
);
    localparam int CNT_REQ  = cnt_bits(PWRUP_CYCLES, SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int CNT_BITS = (CNT_REQ > CNT_W) ? CNT_REQ : CNT_W;
    localparam int PTR_BITS = (WIDTH == DEF_WIDTH) ? PTR_W : $clog2(WIDTH);

    localparam logic [CNT_BITS-1:0] CNT_ZERO    = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0] CNT_ONE     = CNT_BITS'(1'b1);
    localparam logic [CNT_BITS-1:0] PWRUP_LAST  = CNT_BITS'(PWRUP_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] SAMPLE_LAST = CNT_BITS'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(SETTLE_CYCLES - 1);
    localparam logic [PTR_BITS-1:0] PTR_ZERO    = {PTR_BITS{1'b0}};
    localparam logic [PTR_BITS-1:0] PTR_ONE     = PTR_BITS'(1'b1);
    localparam logic [PTR_BITS-1:0] PTR_TOP     = PTR_BITS'(WIDTH - 1);
    localparam logic [WIDTH-1:0]    SAR_MSB     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]    SAR_ZERO    = {WIDTH{1'b0}};

    sar_state_e          state_r, state_s;
    logic [CNT_BITS-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0]    sar_r, sar_s;
    logic [PTR_BITS-1:0] ptr_r, ptr_s, ptr_dec_s;
    logic                overrun_s;
    logic                cmp_s;

    logic                afe_en_r, sample_r, ready_r, busy_r, done_r, overrun_r;
    logic [WIDTH-1:0]    dac_code_r, result_r;

    afe_sync2 u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_i),
        .q   (cmp_s)
    );

    assign ptr_dec_s = ptr_r - PTR_ONE;

    // Next-state, phase counter, SAR trial register and sticky overrun.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sar_s     = sar_r;
        ptr_s     = ptr_r;
        overrun_s = overrun_r;
        if (!ena) begin
            // Power-down wins over everything and also clears the overrun flag.
            state_s   = ST_OFF;
            cnt_s     = CNT_ZERO;
            overrun_s = 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_s = ST_PWRUP;
                    cnt_s   = CNT_ZERO;
                end
                ST_PWRUP: begin
                    if (cnt_r == PWRUP_LAST) begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    cnt_s = CNT_ZERO;
                    if (host.start_i) begin
                        state_s = ST_SAMPLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    overrun_s = overrun_r | host.start_i;
                    if (cnt_r == SAMPLE_LAST) begin
                        state_s = ST_SETTLE;
                        cnt_s   = CNT_ZERO;
                        sar_s   = SAR_MSB;
                        ptr_s   = PTR_TOP;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    overrun_s = overrun_r | host.start_i;
                    if (cnt_r == SETTLE_LAST) begin
                        state_s = ST_DECIDE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DECIDE: begin
                    overrun_s    = overrun_r | host.start_i;
                    // Trial bit is currently 1, so keeping it equals the comparator result.
                    sar_s[ptr_r] = cmp_s;
                    if (ptr_r != PTR_ZERO) begin
                        sar_s[ptr_dec_s] = 1'b1;
                        ptr_s            = ptr_dec_s;
                        state_s          = ST_SETTLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                ST_DONE: begin
                    overrun_s = overrun_r | (host.start_i & ~host.cont_i);
                    cnt_s     = CNT_ZERO;
                    if (host.cont_i) begin
                        state_s = ST_SAMPLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_OFF;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_OFF;
            cnt_r   <= CNT_ZERO;
            sar_r   <= SAR_ZERO;
            ptr_r   <= PTR_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sar_r   <= sar_s;
            ptr_r   <= ptr_s;
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            afe_en_r   <= 1'b0;
            sample_r   <= 1'b0;
            dac_code_r <= SAR_ZERO;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= SAR_ZERO;
            overrun_r  <= 1'b0;
        end else begin
            afe_en_r   <= (state_s != ST_OFF);
            sample_r   <= (state_s == ST_SAMPLE);
            dac_code_r <= (state_s inside {ST_SETTLE, ST_DECIDE}) ? sar_s : SAR_ZERO;
            ready_r    <= (state_s == ST_IDLE);
            busy_r     <= (state_s inside {ST_SAMPLE, ST_SETTLE, ST_DECIDE, ST_DONE});
            done_r     <= (state_s == ST_DONE);
            result_r   <= (state_s == ST_DONE) ? sar_s : result_r;
            overrun_r  <= overrun_s;
        end
    end

    assign afe_en_o       = afe_en_r;
    assign sample_o       = sample_r;
    assign dac_code_o     = dac_code_r;
    assign host.ready_o   = ready_r;
    assign host.busy_o    = busy_r;
    assign host.done_o    = done_r;
    assign host.result_o  = result_r;
    assign host.overrun_o = overrun_r;
endmodule

// File: tb/tb_afe_sar_sequencer.sv
// Directed self-checking bench for afe_sar_sequencer with a behavioural comparator
// model cmp_i = (vin >= dac_code_o).
module tb_afe_sar_sequencer;
    logic       clk;
    logic       rst;
    logic       ena;
    logic       cmp_i;
    logic       afe_en_o;
    logic       sample_o;
    logic [7:0] dac_code_o;
    logic [7:0] vin;

    int pass_cnt;
    int total_cnt;

    afe_sar_if #(.WIDTH(8)) bus ();

    afe_sar_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .host       (bus),
        .cmp_i      (cmp_i),
        .afe_en_o   (afe_en_o),
        .sample_o   (sample_o),
        .dac_code_o (dac_code_o)
    );

    assign cmp_i = (vin >= dac_code_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start a conversion from IDLE and follow it until done_o, recording trial codes.
    task automatic convert(input logic [7:0] v, output logic [63:0] codes,
                           output logic [2:0] samp, output int done_at);
        int n;
        vin = v;
        codes = 64'h0;
        samp = 3'b000;
        done_at = 0;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        n = 1;
        while (done_at == 0 && n <= 80) begin
            if (n <= 3) samp[n-1] = sample_o;
            if (n >= 3 && n <= 38 && ((n - 3) % 5) == 0) codes[63 - 8*((n - 3) / 5) -: 8] = dac_code_o;
            if (bus.done_o === 1'b1) begin
                done_at = n;
            end else begin
                tick;
                n++;
            end
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ena = 1'b0; vin = 8'h00;
        bus.start_i = 1'b0; bus.cont_i = 1'b0;
        repeat (3) tick;
        total_cnt++;
        if ({afe_en_o, sample_o, dac_code_o, bus.ready_o, bus.busy_o, bus.done_o, bus.result_o, bus.overrun_o} !== 21'h0)
            $display("FAIL reset_outputs: got %b %b %h %b %b %b %h %b required all zero", afe_en_o, sample_o,
                     dac_code_o, bus.ready_o, bus.busy_o, bus.done_o, bus.result_o, bus.overrun_o);
        else pass_cnt++;
    endtask

    task automatic test_powerup;
        int n;
        logic side_bad;
        rst = 1'b0; ena = 1'b1;
        tick;
        n = 1;
        side_bad = 1'b0;
        total_cnt++;
        if (afe_en_o !== 1'b1) $display("FAIL pwrup_afe_en: got %b required 1", afe_en_o);
        else pass_cnt++;
        while (bus.ready_o !== 1'b1 && n < 60) begin
            if (n == 5) bus.start_i = 1'b1;
            if (n == 10) bus.start_i = 1'b0;
            if ({sample_o, dac_code_o, bus.busy_o, bus.done_o, bus.overrun_o} !== 12'h000 || afe_en_o !== 1'b1)
                side_bad = 1'b1;
            tick;
            n++;
        end
        total_cnt++;
        if (n !== 17) $display("FAIL pwrup_ready_cycle: got %0d required 17", n);
        else pass_cnt++;
        total_cnt++;
        if (side_bad !== 1'b0) $display("FAIL pwrup_side_outputs: got %b required 0", side_bad);
        else pass_cnt++;
        total_cnt++;
        if ({bus.overrun_o, bus.busy_o} !== 2'b00) $display("FAIL pwrup_start_ignored: got %b required 00", {bus.overrun_o, bus.busy_o});
        else pass_cnt++;
    endtask

    task automatic test_conversion;
        logic [63:0] codes;
        logic [63:0] exp_codes;
        logic [2:0]  samp;
        int          done_at;
        exp_codes = 64'h80C0A0B0A8A4A6A5;
        convert(8'hA5, codes, samp, done_at);
        total_cnt++;
        if (done_at !== 43) $display("FAIL conv_latency: got %0d required 43", done_at);
        else pass_cnt++;
        total_cnt++;
        if (bus.result_o !== 8'hA5) $display("FAIL conv_result: got %h required a5", bus.result_o);
        else pass_cnt++;
        total_cnt++;
        if (codes !== exp_codes) $display("FAIL conv_dac_codes: got %h required %h", codes, exp_codes);
        else pass_cnt++;
        total_cnt++;
        if (samp !== 3'b011) $display("FAIL conv_sample_window: got %b required 011", samp);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({bus.done_o, bus.ready_o, bus.busy_o, bus.result_o} !== 11'b010_1010_0101)
            $display("FAIL conv_after_done: got %b %b %b %h required 0 1 0 a5", bus.done_o, bus.ready_o, bus.busy_o, bus.result_o);
        else pass_cnt++;
    endtask

    task automatic test_extremes;
        logic [7:0]  vins [3];
        logic [63:0] codes;
        logic [2:0]  samp;
        int          done_at;
        vins = '{8'h00, 8'hFF, 8'h80};
        for (int i = 0; i < 3; i++) begin
            convert(vins[i], codes, samp, done_at);
            total_cnt++;
            if (bus.result_o !== vins[i] || done_at !== 43)
                $display("FAIL extreme_%0d: got result %h at cycle %0d required %h at 43", i, bus.result_o, done_at, vins[i]);
            else pass_cnt++;
            tick;
        end
    endtask

    task automatic test_continuous;
        int n, d1, d2;
        logic [7:0] r1, r2;
        vin = 8'h3C;
        bus.cont_i = 1'b1;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        n = 1; d1 = 0; d2 = 0; r1 = 8'h00; r2 = 8'h00;
        while (d2 == 0 && n < 200) begin
            if (bus.done_o === 1'b1) begin
                if (d1 == 0) begin
                    d1 = n; r1 = bus.result_o; vin = 8'hC3;
                end else begin
                    d2 = n; r2 = bus.result_o;
                end
            end
            if (d1 != 0 && n == d1 + 1) bus.cont_i = 1'b0;
            if (d2 == 0) begin
                tick;
                n++;
            end
        end
        total_cnt++;
        if (d1 !== 43) $display("FAIL cont_first_done: got %0d required 43", d1);
        else pass_cnt++;
        total_cnt++;
        if (d2 - d1 !== 43) $display("FAIL cont_spacing: got %0d required 43", d2 - d1);
        else pass_cnt++;
        total_cnt++;
        if ({r1, r2} !== 16'h3CC3) $display("FAIL cont_results: got %h %h required 3c c3", r1, r2);
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({bus.ready_o, bus.overrun_o} !== 2'b10) $display("FAIL cont_back_to_idle: got %b required 10", {bus.ready_o, bus.overrun_o});
        else pass_cnt++;
    endtask

    task automatic test_overrun;
        int n;
        vin = 8'h69;
        bus.start_i = 1'b1;
        tick;
        n = 1;
        total_cnt++;
        if (bus.overrun_o !== 1'b0) $display("FAIL ovr_first_cycle: got %b required 0", bus.overrun_o);
        else pass_cnt++;
        tick;
        n = 2;
        total_cnt++;
        if (bus.overrun_o !== 1'b1) $display("FAIL ovr_set: got %b required 1", bus.overrun_o);
        else pass_cnt++;
        while (bus.done_o !== 1'b1 && n < 80) begin
            if (n == 5) bus.start_i = 1'b0;
            tick;
            n++;
        end
        total_cnt++;
        if (bus.result_o !== 8'h69 || n !== 43) $display("FAIL ovr_result: got %h at cycle %0d required 69 at 43", bus.result_o, n);
        else pass_cnt++;
        repeat (3) tick;
        total_cnt++;
        if ({bus.overrun_o, bus.ready_o} !== 2'b11) $display("FAIL ovr_sticky: got %b required 11", {bus.overrun_o, bus.ready_o});
        else pass_cnt++;
        ena = 1'b0;
        tick;
        total_cnt++;
        if (bus.overrun_o !== 1'b0) $display("FAIL ovr_clear_on_off: got %b required 0", bus.overrun_o);
        else pass_cnt++;
        ena = 1'b1;
        wait_ready(n);
    endtask

    task automatic test_ena_drop;
        logic [63:0] codes;
        logic [2:0]  samp;
        int          done_at, n;
        logic        late_bad;
        convert(8'h11, codes, samp, done_at);
        total_cnt++;
        if (bus.result_o !== 8'h11) $display("FAIL ena_prior_result: got %h required 11", bus.result_o);
        else pass_cnt++;
        tick;
        vin = 8'h5A;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        n = 1;
        while (n < 20) begin
            tick;
            n++;
        end
        ena = 1'b0;
        tick;
        total_cnt++;
        if ({afe_en_o, sample_o, dac_code_o, bus.ready_o, bus.busy_o, bus.done_o, bus.overrun_o} !== 14'h0)
            $display("FAIL ena_off_outputs: got %b %b %h %b %b %b %b required all zero", afe_en_o, sample_o,
                     dac_code_o, bus.ready_o, bus.busy_o, bus.done_o, bus.overrun_o);
        else pass_cnt++;
        late_bad = (bus.result_o !== 8'h11);
        for (int i = 0; i < 30; i++) begin
            tick;
            if (bus.done_o !== 1'b0 || bus.result_o !== 8'h11 || afe_en_o !== 1'b0) late_bad = 1'b1;
        end
        total_cnt++;
        if (late_bad !== 1'b0) $display("FAIL ena_off_hold: got result %h done %b required 11 0", bus.result_o, bus.done_o);
        else pass_cnt++;
        ena = 1'b1;
        wait_ready(n);
        total_cnt++;
        if (n !== 17 || bus.result_o !== 8'h11) $display("FAIL ena_repowerup: got %0d cycles result %h required 17 11", n, bus.result_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        vin = 8'hA5;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        repeat (24) tick;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({afe_en_o, sample_o, dac_code_o, bus.ready_o, bus.busy_o, bus.done_o, bus.result_o, bus.overrun_o} !== 21'h0)
            $display("FAIL reset_mid_outputs: got %b %b %h %b %b %b %h %b required all zero", afe_en_o, sample_o,
                     dac_code_o, bus.ready_o, bus.busy_o, bus.done_o, bus.result_o, bus.overrun_o);
        else pass_cnt++;
        tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset;
        test_powerup;
        test_conversion;
        test_extremes;
        test_continuous;
        test_overrun;
        test_ena_drop;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
